wbuf_ar_gen: RTL

Parametrised AXI4 read-address generator for the weight buffer, replacing the fixed-burst, fire-and-forget address stepper.
- A single start command (base address, total beat count) is split into INCR bursts of up to BURST beats; the last burst is shortened and no burst crosses a 4 KB boundary.
- ARVALID/ARREADY follow the AXI handshake rules, and outstanding bursts are limited.
- Sits between the weight-load controller and the AXI AR channel; R data is consumed by the weight buffer, and this block only observes R-last handshakes.

---
 rtl/wbuf_axi_pkg.sv | 22 ++
 rtl/wbuf_outst_cnt.sv | 42 ++++
 rtl/wbuf_ar_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/wbuf_axi_pkg.sv
// Shared AXI constants, AR generator FSM states and 4 KB boundary helper
// for the weight-buffer read and write address paths.
package wbuf_axi_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned AXI_4K         = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StIssue,
    StWaitCr,
    StDrain
  } ar_state_e;

  // Beats that fit between the given page offset and the next 4 KB boundary.
  function automatic int unsigned beats_to_4k(input logic [11:0] offset,
                                              input int unsigned bpb);
    return (AXI_4K - {20'd0, offset}) / bpb;
  endfunction

endpackage

// File: rtl/wbuf_outst_cnt.sv
// Up/down credit counter tracking accepted bursts awaiting completion,
// with limit compare; decrements at zero are dropped.
module wbuf_outst_cnt
  import wbuf_axi_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned CW       = $clog2(MAX_OUTST + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic below_limit,
  output logic empty
);

  logic [CW-1:0] count_q, count_d;
  logic          dec_ok;

  assign dec_ok = dec && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (inc && !dec_ok) begin
      count_d = count_q + CW'(1);
    end else if (!inc && dec_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign below_limit = (count_q < CW'(MAX_OUTST));
  assign empty       = (count_q == '0);

endmodule

// File: rtl/wbuf_ar_gen.sv
// AXI4 read-address generator for the weight buffer: splits one command into
// INCR bursts, honours 4 KB boundaries and limits outstanding bursts.
module wbuf_ar_gen
  import wbuf_axi_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 128,
  parameter int unsigned BURST     = 16,
  parameter int unsigned LW        = 16,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] num_beats,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] araddr,
  output logic [7:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  output logic          arvalid,
  input  logic          arready,
  input  logic          r_last_hs
);

  localparam int unsigned BPB  = DW / 8;
  localparam int unsigned SIZE = $clog2(BPB);
  // Wide enough for both the beat count and the 4 KB beat limit.
  localparam int unsigned CW   = (LW + 1 > 14) ? LW + 1 : 14;

  localparam logic [AW-1:0] LOW_MASK = AW'(BPB - 1);

  ar_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic          arvalid_q, arvalid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          ar_hs;
  logic          below_limit;
  logic          outst_empty;

  logic [CW-1:0] len_c, rem_c, b4k_c;
  logic [8:0]    beats_c;
  logic [AW-1:0] step_c;
  logic [LW-1:0] rem_next_c;

  assign ar_hs = arvalid_q && arready;

  wbuf_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (ar_hs),
    .dec         (r_last_hs),
    .below_limit (below_limit),
    .empty       (outst_empty)
  );

  always_comb begin
    rem_c = CW'(rem_q);
    b4k_c = CW'(beats_to_4k(addr_q[11:0], BPB));
    len_c = CW'(BURST);
    if (rem_c < len_c) len_c = rem_c;
    if (b4k_c < len_c) len_c = b4k_c;
  end

  // Beats of the burst currently on the bus, recovered from its arlen.
  assign beats_c    = {1'b0, arlen_q} + 9'd1;
  assign step_c     = AW'(beats_c) << SIZE;
  assign rem_next_c = rem_q - LW'(beats_c);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = base_addr & ~LOW_MASK;
          rem_d   = num_beats;
          busy_d  = 1'b1;
          state_d = (num_beats == '0) ? StDrain : StCalc;
        end
      end
      StCalc: begin
        araddr_d = addr_q;
        arlen_d  = 8'(len_c - CW'(1));
        state_d  = below_limit ? StIssue : StWaitCr;
      end
      StIssue: begin
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
        end else if (arready) begin
          arvalid_d = 1'b0;
          addr_d    = addr_q + step_c;
          rem_d     = rem_next_c;
          state_d   = (rem_next_c != '0) ? StCalc : StDrain;
        end
      end
      StWaitCr: begin
        if (below_limit) begin
          state_d = StIssue;
        end
      end
      StDrain: begin
        if (outst_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arvalid = arvalid_q;
  assign arsize  = 3'(SIZE);
  assign arburst = AXI_BURST_INCR;

endmodule
